// File: rtl/joint_rcservo_multi.sv
// Multi-channel RC-servo joint generator: per-channel signed step-rate command
// drives a saturating position counter that is mapped to a frame-latched servo pulse.
module joint_rcservo_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned SERVO_PERIOD = 480000,
  parameter int unsigned SERVO_CENTER = 72000,
  parameter int unsigned PULSE_MIN    = 48000,
  parameter int unsigned PULSE_MAX    = 96000,
  parameter int unsigned SCALE_SHIFT  = 6,
  parameter int unsigned FB_LIMIT     = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     enable,
  input  logic [32*CHANNELS-1:0]  jointFreqCmd,
  output logic [32*CHANNELS-1:0]  jointFeedback,
  output logic [CHANNELS-1:0]     PWM,
  output logic                    frame_strobe
);

  localparam int unsigned FW = (SERVO_PERIOD > 1) ? $clog2(SERVO_PERIOD) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(SERVO_PERIOD - 1);

  localparam logic signed [32:0] CENTER_W = 33'(SERVO_CENTER);
  localparam logic signed [32:0] MIN_W    = 33'(PULSE_MIN);
  localparam logic signed [32:0] MAX_W    = 33'(PULSE_MAX);
  localparam logic signed [31:0] LIM_P    = 32'(FB_LIMIT);
  localparam logic signed [31:0] LIM_N    = -LIM_P;

  // Per-channel state
  logic        [31:0]  cnt_q   [CHANNELS];
  logic        [31:0]  cnt_d   [CHANNELS];
  logic signed [31:0]  fb_q    [CHANNELS];
  logic signed [31:0]  fb_d    [CHANNELS];
  logic        [FW-1:0] width_q [CHANNELS];
  logic [CHANNELS-1:0] phase_q;
  logic [CHANNELS-1:0] phase_d;

  // Shared frame timer
  logic [FW-1:0] frame_cnt;

  // Combinational per-channel helpers
  logic signed [31:0]  cmd     [CHANNELS];
  logic        [31:0]  mag     [CHANNELS];
  logic        [31:0]  half    [CHANNELS];
  logic signed [31:0]  fb_sh   [CHANNELS];
  logic signed [32:0]  w_raw   [CHANNELS];
  logic        [FW-1:0] width_c [CHANNELS];

  // Step generator next-state: half-period counter, phase toggle, saturating step
  always_comb begin
    phase_d = phase_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cmd[i]   = jointFreqCmd[32*i +: 32];
      mag[i]   = cmd[i][31] ? 32'(~cmd[i] + 32'sd1) : 32'(cmd[i]);
      half[i]  = mag[i] >> 1;
      cnt_d[i] = cnt_q[i];
      fb_d[i]  = fb_q[i];

      if (!enable[i] || (cmd[i] == 32'sd0)) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= half[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = ~phase_q[i];
        if (phase_q[i]) begin
          if (!cmd[i][31] && (fb_q[i] < LIM_P)) begin
            fb_d[i] = fb_q[i] + 32'sd1;
          end else if (cmd[i][31] && (fb_q[i] > LIM_N)) begin
            fb_d[i] = fb_q[i] - 32'sd1;
          end
        end
      end else begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
    end
  end

  // Feedback to pulse width: arithmetic shift (rounds toward -inf), then clamp
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      fb_sh[i] = fb_q[i] >>> SCALE_SHIFT;
      w_raw[i] = CENTER_W + $signed({fb_sh[i][31], fb_sh[i]});
      if (w_raw[i] < MIN_W) begin
        width_c[i] = FW'(MIN_W);
      end else if (w_raw[i] > MAX_W) begin
        width_c[i] = FW'(MAX_W);
      end else begin
        width_c[i] = FW'(w_raw[i]);
      end
    end
  end

  // State registers; widths latch only on the frame wrap so a pulse never changes mid-frame
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= FRAME_LAST;
      phase_q   <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i]   <= '0;
        fb_q[i]    <= '0;
        width_q[i] <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
        fb_q[i]  <= fb_d[i];
        if (frame_cnt == FRAME_LAST) begin
          width_q[i] <= width_c[i];
        end
      end
    end
  end

  // Outputs decoded purely from registers
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_out
    assign jointFeedback[32*g +: 32] = fb_q[g];
    assign PWM[g]                    = (frame_cnt < width_q[g]);
  end

  assign frame_strobe = (frame_cnt == '0);

endmodule

// File: tb/tb_joint_rcservo_multi.sv
// Scoreboard bench for joint_rcservo_multi: stimulus queues cycle-tagged expectations,
// a negedge monitor measures feedback, pulse levels, strobes and per-frame pulse widths.
module tb_joint_rcservo_multi;

  localparam int K_FB  = 0;
  localparam int K_PWM = 1;
  localparam int K_STB = 2;
  localparam int K_WID = 3;

  typedef struct {
    int    cyc;
    int    kind;
    int    ch;
    int    val;
    string name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  enable;
  logic [63:0] jointFreqCmd;
  logic [63:0] jointFeedback;
  logic [1:0]  PWM;
  logic        frame_strobe;

  joint_rcservo_multi #(
    .CHANNELS    (2),
    .SERVO_PERIOD(100),
    .SERVO_CENTER(50),
    .PULSE_MIN   (20),
    .PULSE_MAX   (80),
    .SCALE_SHIFT (1),
    .FB_LIMIT    (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .jointFreqCmd (jointFreqCmd),
    .jointFeedback(jointFeedback),
    .PWM          (PWM),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_d = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic expect_at(input int c, input int k, input int ch, input int v, input string nm);
    exp_t e;
    e.cyc = c; e.kind = k; e.ch = ch; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: measure frame widths and retire expectations due this cycle
  int   hi[2];
  int   meas[2];
  logic in_frame = 1'b0;
  logic frame_done;
  int   idx;
  int   act;
  exp_t cur;

  always @(negedge clk) begin
    frame_done = 1'b0;
    if (rst_d) begin
      in_frame = 1'b0;
    end else if (frame_strobe) begin
      if (in_frame) begin
        meas[0] = hi[0];
        meas[1] = hi[1];
        frame_done = 1'b1;
      end
      in_frame = 1'b1;
      hi[0] = 0;
      hi[1] = 0;
    end
    if (in_frame) begin
      for (int c = 0; c < 2; c++) hi[c] += int'(PWM[c]);
    end

    idx = 0;
    while (idx < exp_q.size()) begin
      if (exp_q[idx].cyc > cyc) begin
        idx++;
      end else begin
        cur = exp_q[idx];
        exp_q.delete(idx);
        case (cur.kind)
          K_FB:    act = $signed(jointFeedback[32*cur.ch +: 32]);
          K_PWM:   act = int'(PWM[cur.ch]);
          K_STB:   act = int'(frame_strobe);
          default: act = frame_done ? meas[cur.ch] : -1;
        endcase
        checks++;
        if (cur.cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", cur.name, cur.cyc, cyc);
        end else if (act != cur.val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %0d, expected %0d", cur.name, cyc, act, cur.val);
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    enable       = 2'b00;
    jointFreqCmd = '0;

    // Reset / idle
    expect_at(3, K_FB, 0, 0, "rst_fb0");
    expect_at(3, K_FB, 1, 0, "rst_fb1");
    expect_at(3, K_PWM, 0, 0, "rst_pwm0");
    expect_at(3, K_PWM, 1, 0, "rst_pwm1");
    expect_at(3, K_STB, 0, 0, "rst_strobe");
    goto_cycle(5);
    rst = 1'b0;
    expect_at(6, K_STB, 0, 1, "strobe_first");
    expect_at(7, K_STB, 0, 0, "strobe_low");
    expect_at(205, K_STB, 0, 0, "strobe_pre");
    expect_at(106, K_STB, 0, 1, "strobe_2");
    expect_at(206, K_STB, 0, 1, "strobe_3");
    expect_at(6, K_PWM, 0, 1, "pwm0_start");
    expect_at(55, K_PWM, 0, 1, "pwm0_last_hi");
    expect_at(56, K_PWM, 0, 0, "pwm0_first_lo");
    expect_at(55, K_PWM, 1, 1, "pwm1_last_hi");
    expect_at(56, K_PWM, 1, 0, "pwm1_first_lo");
    expect_at(106, K_WID, 0, 50, "idle_w0_f0");
    expect_at(106, K_WID, 1, 50, "idle_w1_f0");
    expect_at(206, K_WID, 0, 50, "idle_w0_f1");
    expect_at(206, K_WID, 1, 50, "idle_w1_f1");

    // Positive stepping, fb changes mid-pulse must not disturb the current frame
    goto_cycle(206);
    enable = 2'b01;
    jointFreqCmd[31:0] = 32'sd4;
    expect_at(211, K_FB, 0, 0, "pos_before_first");
    expect_at(212, K_FB, 0, 1, "pos_first_step");
    expect_at(266, K_FB, 0, 10, "pos_fb10");
    expect_at(255, K_PWM, 0, 1, "glitch_hi");
    expect_at(256, K_PWM, 0, 0, "glitch_lo");
    expect_at(306, K_WID, 0, 50, "glitch_w0");
    expect_at(306, K_WID, 1, 50, "glitch_w1");

    // Enable low holds fb for 200 cycles
    goto_cycle(266);
    enable = 2'b00;
    expect_at(300, K_FB, 0, 10, "hold_fb_300");
    expect_at(466, K_FB, 0, 10, "hold_fb_466");
    expect_at(360, K_PWM, 0, 1, "w55_hi");
    expect_at(361, K_PWM, 0, 0, "w55_lo");
    expect_at(406, K_WID, 0, 55, "w55_f");
    expect_at(406, K_WID, 1, 50, "w55_ch1");
    expect_at(506, K_WID, 0, 55, "w55_f2");
    expect_at(506, K_WID, 1, 50, "ch1_50_f2");

    // Negative stepping alongside ch0
    goto_cycle(484);
    enable = 2'b11;
    jointFreqCmd[63:32] = -32'sd4;
    expect_at(501, K_FB, 1, -2, "neg_fb_m2");
    expect_at(502, K_FB, 1, -3, "neg_fb_m3");
    expect_at(502, K_FB, 0, 13, "indep_fb13");
    expect_at(606, K_WID, 1, 48, "neg_w48");
    expect_at(606, K_WID, 0, 56, "indep_w56");

    goto_cycle(544);
    enable = 2'b00;
    expect_at(550, K_FB, 0, 20, "indep_fb20");
    expect_at(550, K_FB, 1, -10, "neg_fb_m10");
    expect_at(706, K_WID, 1, 45, "neg_w45");
    expect_at(706, K_WID, 0, 60, "indep_w60");

    // Saturation at +FB_LIMIT and width clamp
    goto_cycle(706);
    enable = 2'b01;
    jointFreqCmd[31:0] = 32'sd1;
    expect_at(707, K_FB, 0, 20, "sat_no_step");
    expect_at(708, K_FB, 0, 21, "sat_step1");
    expect_at(865, K_FB, 0, 99, "sat_fb99");
    expect_at(866, K_FB, 0, 100, "sat_fb100");
    expect_at(870, K_FB, 0, 100, "sat_hold");
    expect_at(1006, K_FB, 0, 100, "sat_hold_300");
    expect_at(806, K_WID, 0, 60, "sat_w_prev");
    expect_at(906, K_WID, 0, 80, "clamp_w80_a");
    expect_at(1006, K_WID, 0, 80, "clamp_w80_b");
    expect_at(1006, K_WID, 1, 45, "sat_ch1_w45");

    goto_cycle(1006);
    jointFreqCmd[31:0] = -32'sd1;
    expect_at(1007, K_FB, 0, 100, "unsat_wait");
    expect_at(1008, K_FB, 0, 99, "unsat_fb99");
    expect_at(1010, K_FB, 0, 98, "unsat_fb98");

    // Synchronous reset mid-pulse
    expect_at(1020, K_PWM, 0, 1, "pre_rst_pwm0");
    expect_at(1020, K_PWM, 1, 1, "pre_rst_pwm1");
    goto_cycle(1020);
    rst          = 1'b1;
    enable       = 2'b00;
    jointFreqCmd = '0;
    expect_at(1021, K_PWM, 0, 0, "midrst_pwm0");
    expect_at(1021, K_PWM, 1, 0, "midrst_pwm1");
    expect_at(1021, K_FB, 0, 0, "midrst_fb0");
    expect_at(1021, K_FB, 1, 0, "midrst_fb1");
    expect_at(1021, K_STB, 0, 0, "midrst_strobe");
    goto_cycle(1022);
    rst = 1'b0;
    expect_at(1023, K_STB, 0, 1, "post_rst_strobe");
    expect_at(1123, K_WID, 0, 50, "post_rst_w0");
    expect_at(1123, K_WID, 1, 50, "post_rst_w1");

    goto_cycle(1130);
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never checked", cur.name, cur.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
